// File: rtl/multicycle_ctrl_pkg.sv
// Shared decode types for the RV32I core plus the control-FSM additions:
// controller states, PC-select encoding, mcause codes and small helpers
// that classify the registered opcode during write-back.
package multicycle_ctrl_pkg;

    // Opcode class produced by the decoder from the current IR.
    typedef enum logic [3:0] {
        invalid,
        lui,
        auipc,
        jal,
        jalr,
        branch_type,
        load_type,
        store_type,
        imm_arith_type,
        reg_arith_type,
        fence_type,
        system_type
    } opcode_t;

    // Sub-kind for system_type instructions.
    typedef enum logic [3:0] {
        sysk_invalid,
        sysk_ecall,
        sysk_ebreak,
        sysk_mret,
        sysk_wfi,
        sysk_csrrw,
        sysk_csrrs,
        sysk_csrrc,
        sysk_csrrwi,
        sysk_csrrsi,
        sysk_csrrci
    } system_kind_t;

    // Controller states.
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } ctrl_state_t;

    // Next-PC source select.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_TRAP   = 2'd2
    } pc_sel_t;

    // mcause exception codes raised by the controller.
    localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

    // CSR read/modify/write kinds: these write both rd and the CSR.
    function automatic logic is_csr_kind(input system_kind_t sk);
        case (sk)
            sysk_csrrw, sysk_csrrs, sysk_csrrc,
            sysk_csrrwi, sysk_csrrsi, sysk_csrrci: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // Instructions that write rd in write-back.
    function automatic logic writes_rf(input opcode_t op, input system_kind_t sk);
        case (op)
            lui, auipc, jal, jalr, load_type,
            imm_arith_type, reg_arith_type: return 1'b1;
            system_type:                    return is_csr_kind(sk);
            default:                        return 1'b0;
        endcase
    endfunction

    // Write-back PC source: jumps always redirect, branches only when taken.
    function automatic pc_sel_t wb_pc_sel(input opcode_t op, input logic taken);
        if (op == jal || op == jalr || (op == branch_type && taken))
            return PC_TARGET;
        return PC_PLUS4;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-wait watchdog. Counts cycles an outstanding request has gone
// without an ack and flags expiry once the count reaches MEM_TIMEOUT.
// The count saturates at the limit so a stalled request never wraps.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count;

    // Clear wins over counting; hold at the limit once reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LIMIT)
            count <= count + CW'(1);
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> (MEM) -> WB,
// with TRAP for decode faults and memory timeouts. Every strobe is a
// register loaded on the transition into the state that owns it, so the
// outputs are Moore functions of the state and the opcode latched in DECODE.
// ir_we is the one combinational output (fetch handshake).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    input  logic         imem_ack,
    output logic         ir_we,
    input  opcode_t      opcode,
    input  system_kind_t sys_kind,
    input  logic         kind_valid,
    input  logic         branch_taken,
    output logic         dmem_req,
    output logic         dmem_we,
    input  logic         dmem_ack,
    output logic         rf_we,
    output logic         csr_we,
    output logic         pc_we,
    output logic [1:0]   pc_sel,
    output logic         trap,
    output logic [3:0]   trap_cause,
    output logic         retire
);

    ctrl_state_t  state;
    opcode_t      op_q;
    system_kind_t sysk_q;

    logic wait_clear;
    logic wait_en;
    logic expired;

    assign ir_we = imem_req & imem_ack;

    // The counter idles at zero whenever no request is outstanding, so it
    // is already cleared on entry to FETCH or MEM. Only one of the two
    // requests is ever high at a time, so one timer serves both ports.
    assign wait_clear = ~(imem_req | dmem_req);
    assign wait_en    = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .enable  (wait_en),
        .expired (expired)
    );

    // State sequencing plus registered strobes for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            op_q       <= invalid;
            sysk_q     <= sysk_invalid;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            csr_we     <= 1'b0;
            pc_we      <= 1'b0;
            pc_sel     <= PC_PLUS4;
            trap       <= 1'b0;
            trap_cause <= '0;
            retire     <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to idle unless re-armed below.
            rf_we      <= 1'b0;
            csr_we     <= 1'b0;
            pc_we      <= 1'b0;
            pc_sel     <= PC_PLUS4;
            trap       <= 1'b0;
            trap_cause <= '0;
            retire     <= 1'b0;

            unique case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        // First cycle after reset: launch the fetch.
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (expired) begin
                        imem_req   <= 1'b0;
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_IFETCH_FAULT;
                        pc_we      <= 1'b1;
                        pc_sel     <= PC_TRAP;
                    end
                end

                S_DECODE: begin
                    op_q   <= opcode;
                    sysk_q <= sys_kind;
                    if (opcode == invalid || !kind_valid) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                        pc_we      <= 1'b1;
                        pc_sel     <= PC_TRAP;
                    end else if (opcode == system_type && sys_kind == sysk_ecall) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ECALL_M;
                        pc_we      <= 1'b1;
                        pc_sel     <= PC_TRAP;
                    end else if (opcode == system_type && sys_kind == sysk_ebreak) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_BREAKPOINT;
                        pc_we      <= 1'b1;
                        pc_sel     <= PC_TRAP;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end

                S_EXECUTE: begin
                    if (op_q == load_type || op_q == store_type) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= (op_q == store_type);
                    end else begin
                        // Fence and non-CSR system kinds fall through with
                        // no register or CSR write; only the PC advances.
                        state  <= S_WB;
                        rf_we  <= writes_rf(op_q, sysk_q);
                        csr_we <= (op_q == system_type) && is_csr_kind(sysk_q);
                        pc_we  <= 1'b1;
                        pc_sel <= wb_pc_sel(op_q, branch_taken);
                        retire <= 1'b1;
                    end
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        // Ack wins even on the expiry cycle.
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= S_WB;
                        rf_we    <= writes_rf(op_q, sysk_q);
                        pc_we    <= 1'b1;
                        pc_sel   <= wb_pc_sel(op_q, branch_taken);
                        retire   <= 1'b1;
                    end else if (expired) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= (op_q == store_type) ? CAUSE_STORE_FAULT
                                                           : CAUSE_LOAD_FAULT;
                        pc_we      <= 1'b1;
                        pc_sel     <= PC_TRAP;
                    end
                end

                S_WB, S_TRAP: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                default: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl with MEM_TIMEOUT = 4. Stimulus
// pushes the expected write-back/trap event (with its absolute cycle) into
// a queue; a negedge monitor pops and compares whenever pc_we is high.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int unsigned MT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         imem_req, ir_we, dmem_req, dmem_we;
    logic         rf_we, csr_we, pc_we, trap, retire;
    logic [1:0]   pc_sel;
    logic [3:0]   trap_cause;
    logic         imem_ack = 1'b0;
    logic         dmem_ack = 1'b0;
    opcode_t      opcode = invalid;
    system_kind_t sys_kind = sysk_invalid;
    logic         kind_valid = 1'b0;
    logic         branch_taken = 1'b0;

    multicycle_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .ir_we        (ir_we),
        .opcode       (opcode),
        .sys_kind     (sys_kind),
        .kind_valid   (kind_valid),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .rf_we        (rf_we),
        .csr_we       (csr_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .retire       (retire)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic       rf_we;
        logic       csr_we;
        logic [1:0] pc_sel;
        logic       trap;
        logic [3:0] cause;
        logic       retire;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic exp_we = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: compare every pc_we event against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (rst_n) begin
            if (dmem_req) check("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
            if (pc_we) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_pc_we: cyc=%0d trap=%b cause=%0d", cyc, trap, trap_cause);
                end else begin
                    e = sb.pop_front();
                    ok = (cyc == e.cyc) && (rf_we == e.rf_we) && (csr_we == e.csr_we) &&
                         (pc_sel == e.pc_sel) && (trap == e.trap) && (retire == e.retire) &&
                         (!e.trap || trap_cause == e.cause);
                    if (ok) n_pass++;
                    else $display("FAIL %s: got cyc=%0d rf=%b csr=%b sel=%0d trap=%b cause=%0d ret=%b, expected cyc=%0d rf=%b csr=%b sel=%0d trap=%b cause=%0d ret=%b",
                                  e.name, cyc, rf_we, csr_we, pc_sel, trap, trap_cause, retire,
                                  e.cyc, e.rf_we, e.csr_we, e.pc_sel, e.trap, e.cause, e.retire);
                end
            end else if (rf_we | csr_we | trap | retire) begin
                n_checks++;
                $display("FAIL stray_strobe: cyc=%0d rf=%b csr=%b trap=%b ret=%b without pc_we",
                         cyc, rf_we, csr_we, trap, retire);
            end
        end
    end

    task automatic wait_ireq(output int c, output bit ok);
        int n = 0;
        while (!imem_req && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        ok = imem_req;
        c = cyc;
        if (!ok) begin
            n_checks++;
            $display("FAIL imem_req_wait: imem_req low for 30 cycles, expected high");
        end
    endtask

    // One instruction: fetch ack in cycle c, expected event at cycle c+lat.
    task automatic run(input string name, input opcode_t op, input system_kind_t sk,
                       input logic kv, input logic tk, input bit do_mem,
                       input int mwait, input bit mack, input int lat,
                       input logic e_rf, input logic e_csr, input logic [1:0] e_sel,
                       input logic e_trap, input logic [3:0] e_cause);
        int   c;
        bit   ok;
        exp_t e;
        wait_ireq(c, ok);
        if (!ok) return;
        opcode = op; sys_kind = sk; kind_valid = kv; branch_taken = tk;
        exp_we = (op == store_type);
        imem_ack = 1'b1;
        #1 check({name, "_ir_we"}, {31'd0, ir_we}, 32'd1);
        e.cyc = c + lat; e.name = name; e.rf_we = e_rf; e.csr_we = e_csr;
        e.pc_sel = e_sel; e.trap = e_trap; e.cause = e_cause; e.retire = !e_trap;
        sb.push_back(e);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        if (do_mem) begin
            repeat (2) begin @(posedge clk); #1; end
            check({name, "_dmem_req"}, {31'd0, dmem_req}, 32'd1);
            repeat (mwait) begin @(posedge clk); #1; end
            if (mack) begin
                dmem_ack = 1'b1;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
            end
        end
    endtask

    task automatic fetch_timeout();
        int   c;
        bit   ok;
        exp_t e;
        wait_ireq(c, ok);
        if (!ok) return;
        e.cyc = c + 5; e.name = "ifetch_timeout"; e.rf_we = 0; e.csr_we = 0;
        e.pc_sel = 2; e.trap = 1; e.cause = 4'd1; e.retire = 0;
        sb.push_back(e);
        repeat (6) begin @(posedge clk); #1; end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {17'd0, imem_req, ir_we, dmem_req, dmem_we, rf_we, csr_we, pc_we,
               pc_sel, trap, trap_cause, retire}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("imem_req_after_reset", {31'd0, imem_req}, 32'd1);

        //   name            opcode          sys_kind      kv tk mem w ack lat rf csr sel trp cause
        run("alu_reg",       reg_arith_type, sysk_invalid, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        run("alu_imm",       imm_arith_type, sysk_invalid, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        run("load_w3",       load_type,      sysk_invalid, 1, 0, 1, 3, 1, 7, 1, 0, 0, 0, 0);
        run("store_w3",      store_type,     sysk_invalid, 1, 0, 1, 3, 1, 7, 0, 0, 0, 0, 0);
        run("load_w0",       load_type,      sysk_invalid, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0);
        run("br_taken",      branch_type,    sysk_invalid, 1, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0);
        run("br_not_taken",  branch_type,    sysk_invalid, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        run("jal",           jal,            sysk_invalid, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
        run("jalr",          jalr,           sysk_invalid, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
        run("csrrs",         system_type,    sysk_csrrs,   1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        run("fence",         fence_type,     sysk_invalid, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        run("illegal_op",    invalid,        sysk_invalid, 1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 4'd2);
        run("bad_kind",      reg_arith_type, sysk_invalid, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 4'd2);
        run("ecall",         system_type,    sysk_ecall,   1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 4'd11);
        run("ebreak",        system_type,    sysk_ebreak,  1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 4'd3);
        run("illegal_first", system_type,    sysk_ecall,   0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 4'd2);
        run("store_timeout", store_type,     sysk_invalid, 1, 0, 1, 0, 0, 8, 0, 0, 2, 1, 4'd7);
        run("load_timeout",  load_type,      sysk_invalid, 1, 0, 1, 0, 0, 8, 0, 0, 2, 1, 4'd5);
        run("store_ack_exp", store_type,     sysk_invalid, 1, 0, 1, 4, 1, 8, 0, 0, 0, 0, 0);
        fetch_timeout();
        run("alu_recover",   reg_arith_type, sysk_invalid, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: no pc_we event seen, expected one at cycle %0d", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
